// File: rtl/cordic_cos_sched_if.sv
// Requester, response and cosine-unit signals shared by cordic_cos_sched and its environment.
// slave = scheduler side, master = requesters / consumer / cosine-unit side.
interface cordic_cos_sched_if #(
    parameter int NREQ = 2
) ();
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_theta;
    logic [NREQ-1:0]    gnt;
    logic [31:0]        cu_theta;
    logic [31:0]        cu_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;

    modport slave (
        input  req, req_theta, cu_result, rsp_ready,
        output gnt, cu_theta, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req, req_theta, cu_result, rsp_ready,
        input  gnt, cu_theta, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/cordic_cos_sched.sv
// Round-robin scheduler sharing one non-stallable pipelined cosine unit, with credit-protected response FIFO.
// Optional statistics ports enabled by defining CORDIC_COS_SCHED_STATS_EN.
module cordic_cos_sched #(
    parameter int NREQ       = 2,
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    cordic_cos_sched_if.slave              bus
`ifdef CORDIC_COS_SCHED_STATS_EN
    ,
    output logic [31:0]                    o_stat_issued,
    output logic [31:0]                    o_stat_stall,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_stat_peak
`endif
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int ICW = $clog2(LATENCY + 2);
    localparam int NST = LATENCY + 1;

    logic [ICW-1:0]    r_inflight;
    logic [FCW-1:0]    r_fifo_count;
    logic [IDW-1:0]    r_rr_ptr;
    logic [NST-1:0]    r_tag_v;
    logic [IDW-1:0]    r_tag_id [NST];
    logic [31:0]       r_cu_theta;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [IDW+31:0]   r_mem [FIFO_DEPTH];

    logic [31:0]       w_occ;
    logic              w_can_issue;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_rsp_valid;
    logic [IDW-1:0]    w_idx;
    logic [IDW-1:0]    w_sel;
    logic [NREQ-1:0]   w_gnt;
    logic [31:0]       w_sel_theta;

    function automatic logic [IDW-1:0] f_wrap(input int v);
        return IDW'(v % NREQ);
    endfunction

    // A same-cycle pop is deliberately not credited back.
    assign w_occ       = 32'(r_inflight) + 32'(r_fifo_count);
    assign w_can_issue = w_occ < 32'(FIFO_DEPTH);

    always_comb begin
        w_issue = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = f_wrap(int'(r_rr_ptr) + k);
            if (!w_issue && w_can_issue && i_reset && bus.req[w_idx]) begin
                w_issue = 1'b1;
                w_sel   = w_idx;
            end
        end
        if (w_issue) w_gnt[w_sel] = 1'b1;
    end

    always_comb begin
        w_sel_theta = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == IDW'(i)) w_sel_theta = bus.req_theta[32*i +: 32];
        end
    end

    assign w_push        = r_tag_v[NST-1];
    assign w_rsp_valid   = (r_fifo_count != '0);
    assign w_pop         = w_rsp_valid & bus.rsp_ready;
    assign bus.gnt       = w_gnt;
    assign bus.cu_theta  = r_cu_theta;
    assign bus.rsp_valid = w_rsp_valid;
    assign {bus.rsp_id, bus.rsp_data} = w_rsp_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cu_theta   <= '0;
            r_rr_ptr     <= '0;
            r_tag_v      <= '0;
            r_inflight   <= '0;
            r_fifo_count <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
        end else begin
            r_tag_v <= {r_tag_v[NST-2:0], w_issue};
            if (w_issue) begin
                r_cu_theta <= w_sel_theta;
                r_rr_ptr   <= f_wrap(int'(w_sel) + 1);
            end
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + ICW'(1);
                2'b01:   r_inflight <= r_inflight - ICW'(1);
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + FCW'(1);
                2'b01:   r_fifo_count <= r_fifo_count - FCW'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
        end
    end

    // IDs and FIFO payload carry no reset; only the valid bits and counters decide what is live.
    always_ff @(posedge i_clk) begin
        r_tag_id[0] <= w_sel;
        for (int s = 1; s < NST; s++) r_tag_id[s] <= r_tag_id[s-1];
        if (w_push) r_mem[r_wptr] <= {r_tag_id[NST-1], bus.cu_result};
    end

`ifdef CORDIC_COS_SCHED_STATS_EN
    logic [31:0]    r_stat_issued;
    logic [31:0]    r_stat_stall;
    logic [FCW-1:0] r_stat_peak;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
            r_stat_peak   <= '0;
        end else begin
            if (w_issue && (r_stat_issued != '1)) r_stat_issued <= r_stat_issued + 32'd1;
            if ((|bus.req) && !w_can_issue && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
            if (r_fifo_count > r_stat_peak) r_stat_peak <= r_fifo_count;
        end
    end

    assign o_stat_issued = r_stat_issued;
    assign o_stat_stall  = r_stat_stall;
    assign o_stat_peak   = r_stat_peak;
`endif
endmodule

// File: tb/tb_cordic_cos_sched.sv
// Bench for cordic_cos_sched: behavioural cosine-unit delay line plus issue-order scoreboard.
module tb_cordic_cos_sched;
    localparam int NREQ       = 2;
    localparam int LATENCY    = 21;
    localparam int FIFO_DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_cos_sched_if #(.NREQ(NREQ)) bus ();

`ifdef CORDIC_COS_SCHED_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
    logic [5:0]  stat_peak;
`endif

    cordic_cos_sched #(
        .NREQ(NREQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .bus(bus)
`ifdef CORDIC_COS_SCHED_STATS_EN
        ,
        .o_stat_issued(stat_issued),
        .o_stat_stall(stat_stall),
        .o_stat_peak(stat_peak)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [39:0] sb [$];
    int glog [$];
    int gcnt      = 0;
    int stall_cnt = 0;
    logic [31:0] mon_th;
    logic [39:0] mon_e;

    // Stand-in cosine unit: exact values for the known angles, a fixed scramble elsewhere.
    function automatic logic [31:0] cos_model(input logic [31:0] th);
        case (th)
            32'h0000_0000: return 32'h3F80_0000;
            32'h3F86_0A92: return 32'h3F00_0000;
            default:       return {th[15:0], th[31:16]} ^ 32'h5A5A_A5A5;
        endcase
    endfunction

    logic [31:0] cu_pipe [LATENCY];
    always @(posedge clk) begin
        cu_pipe[0] <= bus.cu_theta;
        for (int k = 1; k < LATENCY; k++) cu_pipe[k] <= cu_pipe[k-1];
    end
    assign bus.cu_result = cos_model(cu_pipe[LATENCY-1]);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] && bus.gnt[i]) begin
                mon_th = bus.req_theta[32*i +: 32];
                sb.push_back({8'(i), cos_model(mon_th)});
                glog.push_back(i);
                gcnt++;
                chk("credit_limit", 64'(sb.size() <= FIFO_DEPTH), 64'd1);
            end
        end
        if (bus.gnt != '0) chk("gnt_onehot", 64'($countones(bus.gnt)), 64'd1);
        if (rst_n && (bus.req != '0) && (bus.gnt == '0)) stall_cnt++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rsp_id", 64'(bus.rsp_id), 64'(mon_e[39:32]));
                chk("rsp_data", 64'(bus.rsp_data), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic run_cycles(input int n);
        logic [NREQ-1:0] g;
        repeat (n) begin
            @(negedge clk);
            g = bus.gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (g[i]) bus.req_theta[32*i +: 32] = $urandom;
        end
    endtask

    task automatic do_reset();
        bus.req     = 2'b11;
        bus.rsp_ready = 1'b1;
        rst_n       = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_cu_theta", 64'(bus.cu_theta), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        bus.req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        glog.delete();
        gcnt      = 0;
        stall_cnt = 0;
    endtask

    task automatic single_req(input logic [31:0] th, input logic [31:0] exp_d);
        int lat;
        lat = 0;
        bus.req_theta[31:0] = th;
        bus.req = 2'b01;
        @(negedge clk);
        chk("single_gnt", 64'(bus.gnt), 64'd1);
        @(posedge clk);
        #1;
        bus.req = '0;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                lat = j;
                break;
            end
        end
        chk("single_latency", 64'(lat), 64'(LATENCY + 1));
        chk("single_id", 64'(bus.rsp_id), 64'd0);
        chk("single_data", 64'(bus.rsp_data), 64'(exp_d));
    endtask

    task automatic drain();
        for (int j = 0; j < 400; j++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int alt;
        int nv;
        bus.req       = '0;
        bus.req_theta = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        single_req(32'h0000_0000, 32'h3F80_0000);
        drain();

        do_reset();
        bus.req_theta = {32'h3F00_0000, 32'h3F86_0A92};
        bus.req = 2'b11;
        run_cycles(6);
        bus.req = '0;
        chk("rr_count", 64'(glog.size()), 64'd6);
        for (int k = 0; k < glog.size() && k < 6; k++) chk("rr_order", 64'(glog[k]), 64'(k % 2));
        drain();

        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req = 2'b10;
        run_cycles(80);
        chk("bp_grants", 64'(gcnt), 64'd32);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        run_cycles(30);
        chk("bp_one_more", 64'(gcnt), 64'd33);
`ifdef CORDIC_COS_SCHED_STATS_EN
        chk("stat_issued", 64'(stat_issued), 64'd33);
        chk("stat_peak", 64'(stat_peak), 64'd32);
        chk("stat_stall", 64'(stat_stall), 64'(stall_cnt));
`endif
        bus.req = '0;
        bus.rsp_ready = 1'b1;
        drain();

        glog.delete();
        gcnt = 0;
        bus.req = 2'b11;
        run_cycles(200);
        bus.req = '0;
        chk("tp_grants", 64'(gcnt), 64'd200);
        alt = 0;
        for (int k = 1; k < glog.size(); k++) if (glog[k] == glog[k-1]) alt++;
        chk("tp_alternate", 64'(alt), 64'd0);
        drain();

        gcnt = 0;
        bus.req = 2'b01;
        run_cycles(5);
        bus.req = '0;
        chk("mid_grants", 64'(gcnt), 64'd5);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid) nv++;
        end
        chk("mid_no_rsp", 64'(nv), 64'd0);
        @(posedge clk);
        #1;
        single_req(32'h3F86_0A92, 32'h3F00_0000);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
